// File: rtl/dma_scratchpad_ci.sv
// Scratchpad SRAM with a bidirectional burst DMA engine, reachable through the CPU
// custom-instruction interface and acting as a master on the shared system bus.
module dma_scratchpad_ci #(
   parameter logic [7:0] customId    = 8'h00,
   parameter int         ADDR_WIDTH  = 9,
   parameter int         BLOCK_WIDTH = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  ciN,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result,
   output logic        busOut_request,
   input  logic        busIn_grants,
   input  logic [31:0] busIn_address_data,
   input  logic        busIn_end_transaction,
   input  logic        busIn_data_valid,
   input  logic        busIn_busy,
   input  logic        busIn_error,
   output logic [31:0] busOut_address_data,
   output logic [7:0]  busOut_burst_size,
   output logic        busOut_read_n_write,
   output logic        busOut_begin_transaction,
   output logic        busOut_end_transaction,
   output logic        busOut_data_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LW    = (BLOCK_WIDTH > 9) ? BLOCK_WIDTH : 9;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_BEGIN, S_RD, S_WR, S_ENDW, S_NEXT
   } state_t;

   state_t                 state;
   logic                   error_flag;
   logic                   mode_read;
   logic [31:0]            cur_bus_addr;
   logic [ADDR_WIDTH-1:0]  cur_sp_addr;
   logic [BLOCK_WIDTH-1:0] remaining;
   logic [LW-1:0]          burst_len;
   logic [LW-1:0]          word_cnt;

   logic [31:0]            bus_addr_reg;
   logic [ADDR_WIDTH-1:0]  sp_addr_reg;
   logic [BLOCK_WIDTH-1:0] block_size_reg;
   logic [7:0]             burst_size_reg;

   logic [31:0]            mem [DEPTH];
   logic [31:0]            cpu_rd_data;
   logic                   cpu_rd_pending;

   logic                   ci_active;
   logic [2:0]             sel;
   logic                   ci_write;
   logic [ADDR_WIDTH-1:0]  cpu_addr;
   logic                   busy;
   logic                   cfg_we;
   logic                   cpu_we;
   logic                   cpu_rd;
   logic                   start_req;
   logic                   dma_we;
   logic [ADDR_WIDTH-1:0]  dma_rd_addr;
   logic [31:0]            dma_rd_data;
   logic [LW-1:0]          burst_plus;
   logic [LW-1:0]          rem_ext;
   logic [LW-1:0]          next_len;
   logic [31:0]            status_word;
   logic                   unused_bits;

   // Any nonzero bit above the select field turns the access into a harmless no-op.
   assign ci_active   = start && (ciN == customId);
   assign sel         = (valueA[31:13] != '0) ? 3'd6 : valueA[12:10];
   assign ci_write    = valueA[9];
   assign cpu_addr    = valueA[ADDR_WIDTH-1:0];
   assign busy        = (state != S_IDLE);
   assign cfg_we      = ci_active && ci_write && !busy;
   assign cpu_we      = ci_active && ci_write && (sel == 3'd0);
   assign cpu_rd      = ci_active && !ci_write && (sel == 3'd0);
   assign start_req   = cfg_we && (sel == 3'd5) &&
                        ((valueB[1:0] == 2'b01) || (valueB[1:0] == 2'b10));
   assign status_word = {30'd0, error_flag, busy};
   assign unused_bits = &{1'b0, valueA};

   assign dma_we      = (state == S_RD) && busIn_data_valid && !busIn_error;
   assign dma_rd_addr = (state == S_WR) ? cur_sp_addr + ADDR_WIDTH'(1) : cur_sp_addr;
   assign dma_rd_data = mem[dma_rd_addr];

   assign burst_plus  = LW'({1'b0, burst_size_reg}) + LW'(1);
   assign rem_ext     = LW'(remaining);
   assign next_len    = (burst_plus < rem_ext) ? burst_plus : rem_ext;

   // Configuration registers are frozen while a transfer is in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_addr_reg   <= '0;
         sp_addr_reg    <= '0;
         block_size_reg <= '0;
         burst_size_reg <= '0;
         cpu_rd_pending <= 1'b0;
      end else begin
         cpu_rd_pending <= cpu_rd;
         if (cfg_we) begin
            case (sel)
               3'd1:    bus_addr_reg   <= valueB;
               3'd2:    sp_addr_reg    <= valueB[ADDR_WIDTH-1:0];
               3'd3:    block_size_reg <= valueB[BLOCK_WIDTH-1:0];
               3'd4:    burst_size_reg <= valueB[7:0];
               default: ;
            endcase
         end
      end
   end

   // Dual-port scratchpad: the DMA write is issued last so it wins an address collision.
   always_ff @(posedge clock) begin
      if (cpu_we) mem[cpu_addr] <= valueB;
      if (dma_we) mem[cur_sp_addr] <= busIn_address_data;
      if (cpu_rd) cpu_rd_data <= mem[cpu_addr];
   end

   always_comb begin
      done   = cpu_rd_pending || (ci_active && !cpu_rd);
      result = '0;
      if (cpu_rd_pending) begin
         result = cpu_rd_data;
      end else if (ci_active && !ci_write) begin
         case (sel)
            3'd1:    result = bus_addr_reg;
            3'd2:    result = 32'(sp_addr_reg);
            3'd3:    result = 32'(block_size_reg);
            3'd4:    result = 32'(burst_size_reg);
            3'd5:    result = status_word;
            default: result = '0;
         endcase
      end
   end

   // DMA engine; bus outputs are registered and set on entry to the state that owns them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                    <= S_IDLE;
         error_flag               <= 1'b0;
         mode_read                <= 1'b0;
         cur_bus_addr             <= '0;
         cur_sp_addr              <= '0;
         remaining                <= '0;
         burst_len                <= '0;
         word_cnt                 <= '0;
         busOut_request           <= 1'b0;
         busOut_address_data      <= '0;
         busOut_burst_size        <= '0;
         busOut_read_n_write      <= 1'b0;
         busOut_begin_transaction <= 1'b0;
         busOut_end_transaction   <= 1'b0;
         busOut_data_valid        <= 1'b0;
      end else if (busy && busIn_error) begin
         state                    <= S_IDLE;
         error_flag               <= 1'b1;
         busOut_request           <= 1'b0;
         busOut_address_data      <= '0;
         busOut_burst_size        <= '0;
         busOut_read_n_write      <= 1'b0;
         busOut_begin_transaction <= 1'b0;
         busOut_end_transaction   <= 1'b0;
         busOut_data_valid        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_req) begin
                  error_flag   <= 1'b0;
                  mode_read    <= (valueB[1:0] == 2'b01);
                  cur_bus_addr <= bus_addr_reg;
                  cur_sp_addr  <= sp_addr_reg;
                  remaining    <= block_size_reg;
                  if (block_size_reg != '0) begin
                     state          <= S_REQ;
                     busOut_request <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (busIn_grants) begin
                  state                    <= S_BEGIN;
                  busOut_begin_transaction <= 1'b1;
                  busOut_address_data      <= cur_bus_addr;
                  busOut_read_n_write      <= mode_read;
                  busOut_burst_size        <= 8'(next_len - LW'(1));
                  burst_len                <= next_len;
                  word_cnt                 <= '0;
               end
            end
            S_BEGIN: begin
               busOut_begin_transaction <= 1'b0;
               busOut_read_n_write      <= 1'b0;
               busOut_burst_size        <= '0;
               if (mode_read) begin
                  state               <= S_RD;
                  busOut_address_data <= '0;
               end else begin
                  state               <= S_WR;
                  busOut_data_valid   <= 1'b1;
                  busOut_address_data <= dma_rd_data;
               end
            end
            S_RD: begin
               if (busIn_data_valid) cur_sp_addr <= cur_sp_addr + ADDR_WIDTH'(1);
               if (busIn_end_transaction) begin
                  state          <= S_NEXT;
                  busOut_request <= 1'b0;
               end
            end
            S_WR: begin
               if (!busIn_busy) begin
                  cur_sp_addr <= cur_sp_addr + ADDR_WIDTH'(1);
                  if (word_cnt == burst_len - LW'(1)) begin
                     state                  <= S_ENDW;
                     busOut_data_valid      <= 1'b0;
                     busOut_address_data    <= '0;
                     busOut_end_transaction <= 1'b1;
                  end else begin
                     word_cnt            <= word_cnt + LW'(1);
                     busOut_address_data <= dma_rd_data;
                  end
               end
            end
            S_ENDW: begin
               state                  <= S_NEXT;
               busOut_end_transaction <= 1'b0;
               busOut_request         <= 1'b0;
            end
            S_NEXT: begin
               cur_bus_addr <= cur_bus_addr + (32'(burst_len) << 2);
               remaining    <= remaining - BLOCK_WIDTH'(burst_len);
               if (remaining == BLOCK_WIDTH'(burst_len)) begin
                  state <= S_IDLE;
               end else begin
                  state          <= S_REQ;
                  busOut_request <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_scratchpad_ci.sv
// Bench for dma_scratchpad_ci: CI accesses go through a result scoreboard and a
// small bus-slave model checks burst headers and write data against expected queues.
module tb_dma_scratchpad_ci;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  ciN;
   logic [31:0] valueA, valueB;
   logic        done;
   logic [31:0] result;
   logic        busOut_request, busIn_grants;
   logic [31:0] busIn_address_data;
   logic        busIn_end_transaction, busIn_data_valid, busIn_busy, busIn_error;
   logic [31:0] busOut_address_data;
   logic [7:0]  busOut_burst_size;
   logic        busOut_read_n_write, busOut_begin_transaction;
   logic        busOut_end_transaction, busOut_data_valid;

   dma_scratchpad_ci #(.customId(8'h00), .ADDR_WIDTH(9), .BLOCK_WIDTH(10)) dut (
      .clock(clock), .reset(reset), .start(start), .ciN(ciN),
      .valueA(valueA), .valueB(valueB), .done(done), .result(result),
      .busOut_request(busOut_request), .busIn_grants(busIn_grants),
      .busIn_address_data(busIn_address_data),
      .busIn_end_transaction(busIn_end_transaction),
      .busIn_data_valid(busIn_data_valid), .busIn_busy(busIn_busy),
      .busIn_error(busIn_error), .busOut_address_data(busOut_address_data),
      .busOut_burst_size(busOut_burst_size), .busOut_read_n_write(busOut_read_n_write),
      .busOut_begin_transaction(busOut_begin_transaction),
      .busOut_end_transaction(busOut_end_transaction),
      .busOut_data_valid(busOut_data_valid)
   );

   always #5 clock = ~clock;

   typedef struct { logic [31:0] val; int lat; bit chk; } ci_exp_t;
   typedef struct { logic [31:0] addr; logic [7:0] size; logic rnw; } burst_t;

   ci_exp_t     ci_q[$];
   burst_t      burst_q[$];
   logic [31:0] wr_q[$];

   int test_count = 0;
   int fail_count = 0;

   bit          err_inject = 0;
   bit          hold_busy  = 0;
   int          stall_left = 0;
   int          wr_accepts = 0;
   int          end_count  = 0;
   bit          rd_active  = 0;
   int          rd_len, rd_sent, wr_idx;
   logic [31:0] rd_addr;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] va(input logic [2:0] sel, input logic wr,
                                      input logic [8:0] addr);
      logic [31:0] v;
      v        = 32'(addr);
      v[12:10] = sel;
      v[9]     = wr;
      return v;
   endfunction

   // Called and returns at one time unit after a rising edge.
   task automatic ci_access(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int lat);
      start  = 1'b1;
      ciN    = 8'h00;
      valueA = a;
      valueB = b;
      lat    = 0;
      #1;
      while (!done && lat < 4) begin
         @(posedge clock); #1;
         start = 1'b0;
         lat++;
      end
      res = result;
      if (!done) lat = -1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_val, input int exp_lat, input bit chk);
      ci_exp_t     e;
      logic [31:0] res;
      int          lat;
      e.val = exp_val; e.lat = exp_lat; e.chk = chk;
      ci_q.push_back(e);
      ci_access(a, b, res, lat);
      e = ci_q.pop_front();
      if (e.chk) checkOutput({tag, "_data"}, res, e.val);
      checkOutput({tag, "_lat"}, 32'(lat), 32'(e.lat));
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] r;
      int          l;
      int          n;
      n = 0;
      do begin
         ci_access(va(3'd5, 1'b0, 9'd0), 32'd0, r, l);
         n++;
      end while (r[0] && n < 300);
      checkOutput({tag, "_finish"}, 32'(r[0]), 32'd0);
   endtask

   // Bus slave model, acting one time unit after each rising edge.
   initial begin
      logic [31:0] exp_w;
      burst_t      bexp;
      busIn_grants = 0; busIn_address_data = 0; busIn_end_transaction = 0;
      busIn_data_valid = 0; busIn_busy = 0; busIn_error = 0;
      forever begin
         @(posedge clock); #1;
         busIn_data_valid      = 1'b0;
         busIn_end_transaction = 1'b0;
         busIn_error           = 1'b0;
         busIn_address_data    = '0;
         busIn_busy            = 1'b0;
         busIn_grants          = busOut_request;
         if (reset) begin
            rd_active = 0;
            wr_idx    = 0;
         end
         if (rd_active) begin
            if (err_inject && rd_sent == 2) begin
               busIn_error = 1'b1;
               rd_active   = 0;
               err_inject  = 0;
            end else if (rd_sent < rd_len) begin
               busIn_data_valid   = 1'b1;
               busIn_address_data = 32'hA0 + ((rd_addr - 32'h100) >> 2) + 32'(rd_sent);
               rd_sent++;
            end else begin
               busIn_end_transaction = 1'b1;
               rd_active = 0;
            end
         end
         if (busOut_data_valid) begin
            if (hold_busy) begin
               busIn_busy = 1'b1;
            end else if (wr_idx == 1 && stall_left > 0) begin
               busIn_busy = 1'b1;
               stall_left--;
               exp_w = (wr_q.size() > 0) ? wr_q[0] : 32'hBAD0BAD0;
               checkOutput("wr_hold", busOut_address_data, exp_w);
            end else begin
               exp_w = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hBAD0BAD0;
               checkOutput("wr_data", busOut_address_data, exp_w);
               wr_accepts++;
               wr_idx++;
            end
         end
         if (busOut_end_transaction) end_count++;
         if (busOut_begin_transaction) begin
            checkOutput("burst_expected", 32'(burst_q.size() > 0), 32'd1);
            if (burst_q.size() > 0) begin
               bexp = burst_q.pop_front();
               checkOutput("burst_addr", busOut_address_data, bexp.addr);
               checkOutput("burst_size", 32'(busOut_burst_size), 32'(bexp.size));
               checkOutput("burst_rnw", 32'(busOut_read_n_write), 32'(bexp.rnw));
            end
            if (busOut_read_n_write) begin
               rd_active = 1;
               rd_len    = int'(busOut_burst_size) + 1;
               rd_sent   = 0;
               rd_addr   = busOut_address_data;
            end
            wr_idx = 0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_busctl", 32'({busOut_request, busOut_begin_transaction,
                  busOut_end_transaction, busOut_data_valid, busOut_read_n_write,
                  busOut_burst_size}), 32'd0);
      checkOutput("rst_busdata", busOut_address_data, 32'd0);

      // Register round trip and the no-op selects
      applyStimulus("wr_busaddr", va(3'd1, 1'b1, 9'd0), 32'h1000, 0, 0, 0);
      applyStimulus("wr_block", va(3'd3, 1'b1, 9'd0), 32'd5, 0, 0, 0);
      applyStimulus("wr_burst", va(3'd4, 1'b1, 9'd0), 32'd3, 0, 0, 0);
      applyStimulus("rd_busaddr", va(3'd1, 1'b0, 9'd0), 0, 32'h1000, 0, 1);
      applyStimulus("rd_block", va(3'd3, 1'b0, 9'd0), 0, 32'd5, 0, 1);
      applyStimulus("rd_burst", va(3'd4, 1'b0, 9'd0), 0, 32'd3, 0, 1);
      applyStimulus("rd_status0", va(3'd5, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("rd_sel6", va(3'd6, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("rd_highbits", va(3'd1, 1'b0, 9'd0) | 32'h0000_2000, 0, 32'd0, 0, 1);

      // Scratchpad CI port
      applyStimulus("sp_wr7", va(3'd0, 1'b1, 9'd7), 32'hDEADBEEF, 0, 0, 0);
      applyStimulus("sp_rd7", va(3'd0, 1'b0, 9'd7), 0, 32'hDEADBEEF, 1, 1);
      applyStimulus("sp_wr207", 32'h0000_0207, 32'hCAFEF00D, 0, 0, 0);
      applyStimulus("sp_rd7_alias", va(3'd0, 1'b0, 9'd7), 0, 32'hCAFEF00D, 1, 1);

      // Ignored control codes and zero-length block
      applyStimulus("ctl_00", va(3'd5, 1'b1, 9'd0), 32'd0, 0, 0, 0);
      applyStimulus("st_after00", va(3'd5, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("ctl_11", va(3'd5, 1'b1, 9'd0), 32'd3, 0, 0, 0);
      applyStimulus("st_after11", va(3'd5, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("wr_block0", va(3'd3, 1'b1, 9'd0), 32'd0, 0, 0, 0);
      applyStimulus("ctl_blk0", va(3'd5, 1'b1, 9'd0), 32'd1, 0, 0, 0);
      applyStimulus("st_blk0", va(3'd5, 1'b0, 9'd0), 0, 32'd0, 0, 1);

      // Read DMA: 5 words in bursts of 4 + 1
      applyStimulus("rdma_bus", va(3'd1, 1'b1, 9'd0), 32'h100, 0, 0, 0);
      applyStimulus("rdma_sp", va(3'd2, 1'b1, 9'd0), 32'd0, 0, 0, 0);
      applyStimulus("rdma_blk", va(3'd3, 1'b1, 9'd0), 32'd5, 0, 0, 0);
      applyStimulus("rdma_bst", va(3'd4, 1'b1, 9'd0), 32'd3, 0, 0, 0);
      burst_q.push_back('{addr: 32'h100, size: 8'd3, rnw: 1'b1});
      burst_q.push_back('{addr: 32'h110, size: 8'd0, rnw: 1'b1});
      applyStimulus("rdma_go", va(3'd5, 1'b1, 9'd0), 32'd1, 0, 0, 0);
      wait_idle("rdma");
      applyStimulus("rdma_status", va(3'd5, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      checkOutput("rdma_bursts_left", 32'(burst_q.size()), 32'd0);
      for (int i = 0; i < 5; i++)
         applyStimulus($sformatf("rdma_sp%0d", i), va(3'd0, 1'b0, 9'(i)), 0,
                       32'hA0 + 32'(i), 1, 1);

      // Write DMA with a two-cycle stall on word 1
      for (int i = 0; i < 3; i++)
         applyStimulus("wdma_fill", va(3'd0, 1'b1, 9'(32 + i)), 32'h11110000 + 32'(i), 0, 0, 0);
      applyStimulus("wdma_bus", va(3'd1, 1'b1, 9'd0), 32'h200, 0, 0, 0);
      applyStimulus("wdma_sp", va(3'd2, 1'b1, 9'd0), 32'd32, 0, 0, 0);
      applyStimulus("wdma_blk", va(3'd3, 1'b1, 9'd0), 32'd3, 0, 0, 0);
      burst_q.push_back('{addr: 32'h200, size: 8'd2, rnw: 1'b0});
      for (int i = 0; i < 3; i++) wr_q.push_back(32'h11110000 + 32'(i));
      stall_left = 2; wr_accepts = 0; end_count = 0;
      applyStimulus("wdma_go", va(3'd5, 1'b1, 9'd0), 32'd2, 0, 0, 0);
      wait_idle("wdma");
      checkOutput("wdma_accepts", 32'(wr_accepts), 32'd3);
      checkOutput("wdma_endpulses", 32'(end_count), 32'd1);
      checkOutput("wdma_words_left", 32'(wr_q.size()), 32'd0);
      checkOutput("wdma_stalls_used", 32'(stall_left), 32'd0);

      // Bus error mid-burst, then restart clears the sticky bit
      applyStimulus("err_bus", va(3'd1, 1'b1, 9'd0), 32'h100, 0, 0, 0);
      applyStimulus("err_sp", va(3'd2, 1'b1, 9'd0), 32'h40, 0, 0, 0);
      applyStimulus("err_blk", va(3'd3, 1'b1, 9'd0), 32'd5, 0, 0, 0);
      applyStimulus("err_bst", va(3'd4, 1'b1, 9'd0), 32'd7, 0, 0, 0);
      burst_q.push_back('{addr: 32'h100, size: 8'd4, rnw: 1'b1});
      err_inject = 1;
      applyStimulus("err_go", va(3'd5, 1'b1, 9'd0), 32'd1, 0, 0, 0);
      wait_idle("err");
      applyStimulus("err_status", va(3'd5, 1'b0, 9'd0), 0, 32'd2, 0, 1);
      checkOutput("err_request", 32'(busOut_request), 32'd0);
      burst_q.push_back('{addr: 32'h100, size: 8'd4, rnw: 1'b1});
      applyStimulus("err_restart", va(3'd5, 1'b1, 9'd0), 32'd1, 0, 0, 0);
      applyStimulus("err_cleared", va(3'd5, 1'b0, 9'd0), 0, 32'd1, 0, 1);
      applyStimulus("busy_wr_ign", va(3'd1, 1'b1, 9'd0), 32'hFFFF, 0, 0, 0);
      wait_idle("restart");
      applyStimulus("busy_rd_bus", va(3'd1, 1'b0, 9'd0), 0, 32'h100, 0, 1);
      applyStimulus("restart_status", va(3'd5, 1'b0, 9'd0), 0, 32'd0, 0, 1);

      // Async reset while a write burst is stalled
      applyStimulus("rst_bus", va(3'd1, 1'b1, 9'd0), 32'h300, 0, 0, 0);
      applyStimulus("rst_sp", va(3'd2, 1'b1, 9'd0), 32'd32, 0, 0, 0);
      burst_q.push_back('{addr: 32'h300, size: 8'd4, rnw: 1'b0});
      hold_busy = 1;
      applyStimulus("rst_go", va(3'd5, 1'b1, 9'd0), 32'd2, 0, 0, 0);
      repeat (6) @(posedge clock);
      #1;
      checkOutput("rst_pre_dv", 32'(busOut_data_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("arst_busctl", 32'({busOut_request, busOut_begin_transaction,
                  busOut_end_transaction, busOut_data_valid, busOut_read_n_write,
                  busOut_burst_size}), 32'd0);
      checkOutput("arst_busdata", busOut_address_data, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      hold_busy = 0;
      wr_q.delete();
      applyStimulus("arst_status", va(3'd5, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("arst_bus", va(3'd1, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("arst_sp", va(3'd2, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("arst_blk", va(3'd3, 1'b0, 9'd0), 0, 32'd0, 0, 1);
      applyStimulus("arst_bst", va(3'd4, 1'b0, 9'd0), 0, 32'd0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
